// File: rtl/oc_pkg.sv
// Shared types and constants for the ones' complement checksum controller.
package oc_pkg;

  localparam int unsigned WORD_W = 4;
  localparam logic [WORD_W-1:0] OC_NEG_ZERO = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/oc_adder.sv
// Combinational 4-bit ones' complement adder with end-around carry.
module oc_adder
  import oc_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);

  logic [WORD_W:0] t;

  // Folding the carry back in cannot overflow a second time, so one fold is enough.
  always_comb begin
    t = {1'b0, a} + {1'b0, b};
    y = t[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, t[WORD_W]};
  end

endmodule

// File: rtl/oc_checksum_ctrl.sv
// Streams len words through oc_adder and reports the ones' complement checksum.
// Optional OC_VERIFY_EN adds the 'ok' output (final sum equals negative zero).
module oc_checksum_ctrl
  import oc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] len,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] sum,
  output logic [WORD_W-1:0] checksum
`ifdef OC_VERIFY_EN
  ,
  output logic              ok
`endif
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [WORD_W-1:0] checksum_q, checksum_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] add_y;
`ifdef OC_VERIFY_EN
  logic              ok_q, ok_d;
`endif

  oc_adder u_adder (
    .a (sum_q),
    .b (in_data),
    .y (add_y)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    checksum_d = checksum_q;
`ifdef OC_VERIFY_EN
    ok_d       = ok_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sum_d = '0;
          if (len == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = len;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          sum_d = add_y;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WORD_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Result registers load only on entry to DONE and then hold.
    if (state_d == DONE) begin
      checksum_d = ~sum_d;
`ifdef OC_VERIFY_EN
      ok_d       = (sum_d == OC_NEG_ZERO);
`endif
    end

    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      checksum_q <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OC_VERIFY_EN
      ok_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef OC_VERIFY_EN
      ok_q       <= ok_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign checksum = checksum_q;
`ifdef OC_VERIFY_EN
  assign ok       = ok_q;
`endif

endmodule

// File: tb/tb_oc_checksum_ctrl.sv
// Self-checking bench for oc_checksum_ctrl: directed cases plus randomized runs
// scored against an arithmetic ones' complement reference model.
module tb_oc_checksum_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [3:0] in_data;
  wire        in_ready;
  wire        busy;
  wire        done;
  wire  [3:0] sum;
  wire  [3:0] checksum;
`ifdef OC_VERIFY_EN
  wire        ok;
`endif

  oc_checksum_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .checksum (checksum)
`ifdef OC_VERIFY_EN
    ,
    .ok       (ok)
`endif
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] wbuf [15];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ones' complement addition modulo 15 with 0xF kept as negative zero.
  function automatic logic [3:0] oc_ref(input logic [3:0] a, input logic [3:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s > 15) s = s - 15;
    return s[3:0];
  endfunction

  // Runs one transaction of n words from wbuf; optional stall before word
  // stall_idx and an ignored start pulse in the second busy cycle.
  task automatic run(input string tag, input int n, input int stall_idx,
                     input int stall_cycles, input bit poke);
    int         idx;
    int         stall_left;
    int         done_c;
    int         exp_lat;
    bit         ready_seen;
    logic [3:0] exp_sum;
    exp_sum    = '0;
    idx        = 0;
    stall_left = stall_cycles;
    done_c     = -1;
    ready_seen = 1'b0;
    exp_lat    = n + 1 + ((stall_idx < n) ? stall_cycles : 0);

    start    = 1'b1;
    len      = n[3:0];
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 4'($urandom);
    @(negedge clk);
    start = 1'b0;
    len   = 4'($urandom);

    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        done_c = c;
        break;
      end
      if (in_ready) ready_seen = 1'b1;
      check({tag, ":busy"}, {7'd0, busy}, 8'd1);
      check({tag, ":run_sum"}, {4'd0, sum}, {4'd0, exp_sum});
      start   = poke && (c == 2);
      in_data = 4'($urandom);
      if (in_ready && idx < n && !(idx == stall_idx && stall_left > 0)) begin
        in_valid = 1'b1;
        in_data  = wbuf[idx];
        exp_sum  = oc_ref(exp_sum, wbuf[idx]);
        idx++;
      end else if (in_ready) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;

    check({tag, ":done_latency"}, done_c[7:0], exp_lat[7:0]);
    check({tag, ":sum"}, {4'd0, sum}, {4'd0, exp_sum});
    check({tag, ":checksum"}, {4'd0, checksum}, {4'd0, ~exp_sum});
    check({tag, ":ready_in_done"}, {7'd0, in_ready}, 8'd0);
    check({tag, ":ready_seen"}, {7'd0, ready_seen}, {7'd0, n != 0});
`ifdef OC_VERIFY_EN
    check({tag, ":ok"}, {7'd0, ok}, {7'd0, exp_sum == 4'hF});
`endif
    @(negedge clk);
    check({tag, ":done_pulse"}, {7'd0, done}, 8'd0);
    check({tag, ":idle"}, {7'd0, busy}, 8'd0);
    check({tag, ":sum_hold"}, {4'd0, sum}, {4'd0, exp_sum});
    check({tag, ":checksum_hold"}, {4'd0, checksum}, {4'd0, ~exp_sum});
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst:in_ready", {7'd0, in_ready}, 8'd0);
    check("rst:busy", {7'd0, busy}, 8'd0);
    check("rst:done", {7'd0, done}, 8'd0);
    check("rst:sum", {4'd0, sum}, 8'd0);
    check("rst:checksum", {4'd0, checksum}, 8'd0);
`ifdef OC_VERIFY_EN
    check("rst:ok", {7'd0, ok}, 8'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    wbuf[0] = 4'h3; wbuf[1] = 4'h5;
    run("w35", 2, 99, 0, 1'b0);
    wbuf[0] = 4'hA; wbuf[1] = 4'h9;
    run("wA9", 2, 99, 0, 1'b0);
    wbuf[0] = 4'h8; wbuf[1] = 4'h8;
    run("w88", 2, 99, 0, 1'b0);
    wbuf[0] = 4'hA; wbuf[1] = 4'h9; wbuf[2] = 4'hB;
    run("wA9B", 3, 99, 0, 1'b0);
    wbuf[2] = 4'hC;
    run("wA9C", 3, 99, 0, 1'b0);
    run("len0", 0, 99, 0, 1'b0);
    wbuf[0] = 4'h4; wbuf[1] = 4'h6; wbuf[2] = 4'hC;
    run("stall", 3, 1, 2, 1'b1);

    // Reset in the middle of a run, after one accepted word.
    start = 1'b1;
    len   = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h7;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid:sum", {4'd0, sum}, 8'h07);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst:in_ready", {7'd0, in_ready}, 8'd0);
    check("mid_rst:busy", {7'd0, busy}, 8'd0);
    check("mid_rst:done", {7'd0, done}, 8'd0);
    check("mid_rst:sum", {4'd0, sum}, 8'd0);
    check("mid_rst:checksum", {4'd0, checksum}, 8'd0);
    wbuf[0] = 4'h1; wbuf[1] = 4'h2;
    run("after_rst", 2, 99, 0, 1'b0);
    check("after_rst:checksum_C", {4'd0, checksum}, 8'h0C);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(0, 15));
      for (int i = 0; i < 15; i++) wbuf[i] = 4'($urandom);
      run("rand", n, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
